// File: rtl/adbg_run_ctrl_pkg.sv
// Shared types for the per-core debug run-control block: command opcodes
// and the per-core run state.
package adbg_run_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_HALT   = 2'd0,
        CMD_RESUME = 2'd1,
        CMD_STEP   = 2'd2,
        CMD_CLEAR  = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_WAIT = 2'd1,
        ST_HALTED    = 2'd2,
        ST_STEP      = 2'd3
    } run_state_e;

endpackage

// File: rtl/adbg_core_run_fsm.sv
// Run-control FSM for a single core: halt/resume/step sequencing, halt-ack
// wait counter with forced-halt timeout, and the sticky bp/timeout flags.
module adbg_core_run_fsm
    import adbg_run_ctrl_pkg::*;
#(
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       bp_i,          // own breakpoint OR group trigger
    input  logic       halted_i,
    input  logic       cmd_halt_i,    // strobes are only high on an accepted command
    input  logic       cmd_resume_i,
    input  logic       cmd_step_i,
    input  logic       cmd_clear_i,
    output logic       stall_o,
    output logic       status_halted_o,
    output logic       status_bp_o,
    output logic       status_timeout_o,
    output run_state_e state_o
);

    localparam int unsigned      CNT_W   = $clog2(HALT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALT_TIMEOUT);

    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bp_flag_q, bp_flag_d;
    logic             to_flag_q, to_flag_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            bp_flag_q <= 1'b0;
            to_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bp_flag_q <= bp_flag_d;
            to_flag_q <= to_flag_d;
        end
    end

    // The counter idles at zero so every HALT_WAIT entry starts a fresh wait.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        bp_flag_d = bp_flag_q;
        to_flag_d = to_flag_q;
        unique case (state_q)
            ST_RUN: begin
                if (bp_i) begin
                    state_d   = ST_HALT_WAIT;
                    bp_flag_d = 1'b1;
                end else if (cmd_halt_i) begin
                    state_d = ST_HALT_WAIT;
                end
            end
            ST_HALT_WAIT: begin
                if (halted_i) begin
                    state_d = ST_HALTED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = ST_HALTED;
                    to_flag_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HALTED: begin
                if (cmd_resume_i) begin
                    state_d   = ST_RUN;
                    bp_flag_d = 1'b0;
                end else if (cmd_step_i) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT_WAIT;
                if (bp_i) begin
                    bp_flag_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (cmd_clear_i) begin
            to_flag_d = 1'b0;
        end
    end

    // A breakpoint stalls combinationally, before the FSM has reacted.
    assign stall_o          = bp_i | (state_q == ST_HALT_WAIT) | (state_q == ST_HALTED);
    assign status_halted_o  = (state_q == ST_HALTED);
    assign status_bp_o      = bp_flag_q;
    assign status_timeout_o = to_flag_q;
    assign state_o          = state_q;

endmodule

// File: rtl/adbg_core_run_ctrl.sv
// Multi-core run control: group-trigger fan-out, command handshake and
// decode, and one run FSM per core.
module adbg_core_run_ctrl
    import adbg_run_ctrl_pkg::*;
#(
    parameter int unsigned NB_CORES     = 4,
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic                cpu_clk_i,
    input  logic                cpu_rstn_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_op_i,
    input  logic [NB_CORES-1:0] cmd_mask_i,
    input  logic [NB_CORES-1:0] group_mask_i,
    input  logic [NB_CORES-1:0] bp_i,
    input  logic [NB_CORES-1:0] halted_i,
    output logic [NB_CORES-1:0] cpu_stall_o,
    output logic [NB_CORES-1:0] status_halted_o,
    output logic [NB_CORES-1:0] status_bp_o,
    output logic [NB_CORES-1:0] status_timeout_o
);

    // Handshake: a command is taken on any cycle where cmd_valid_i and
    // cmd_ready_o are both high; ready drops while any core is mid-halt or stepping.
    logic                grp_hit;
    logic [NB_CORES-1:0] grp_term;
    logic [NB_CORES-1:0] bp_eff;
    logic [NB_CORES-1:0] busy;
    logic                cmd_acc;
    logic [NB_CORES-1:0] halt_vec, resume_vec, step_vec, clear_vec;
    run_state_e          core_state [NB_CORES];

    assign grp_hit     = |(bp_i & group_mask_i);
    assign grp_term    = group_mask_i & {NB_CORES{grp_hit}};
    assign bp_eff      = bp_i | grp_term;
    assign cmd_ready_o = ~|busy;
    assign cmd_acc     = cmd_valid_i & cmd_ready_o;

    always_comb begin
        halt_vec   = '0;
        resume_vec = '0;
        step_vec   = '0;
        clear_vec  = '0;
        if (cmd_acc) begin
            unique case (cmd_op_e'(cmd_op_i))
                CMD_HALT:   halt_vec   = cmd_mask_i;
                CMD_RESUME: resume_vec = cmd_mask_i;
                CMD_STEP:   step_vec   = cmd_mask_i;
                CMD_CLEAR:  clear_vec  = cmd_mask_i;
                default:    halt_vec   = '0;
            endcase
        end
    end

    for (genvar i = 0; i < NB_CORES; i++) begin : g_core
        adbg_core_run_fsm #(
            .HALT_TIMEOUT(HALT_TIMEOUT)
        ) u_fsm (
            .clk_i           (cpu_clk_i),
            .rst_ni          (cpu_rstn_i),
            .bp_i            (bp_eff[i]),
            .halted_i        (halted_i[i]),
            .cmd_halt_i      (halt_vec[i]),
            .cmd_resume_i    (resume_vec[i]),
            .cmd_step_i      (step_vec[i]),
            .cmd_clear_i     (clear_vec[i]),
            .stall_o         (cpu_stall_o[i]),
            .status_halted_o (status_halted_o[i]),
            .status_bp_o     (status_bp_o[i]),
            .status_timeout_o(status_timeout_o[i]),
            .state_o         (core_state[i])
        );
        assign busy[i] = (core_state[i] == ST_HALT_WAIT) || (core_state[i] == ST_STEP);
    end

endmodule

// File: tb/tb_adbg_core_run_ctrl.sv
// Self-checking bench for adbg_core_run_ctrl: directed scenarios plus a
// randomized run against a per-core behavioural model.
module tb_adbg_core_run_ctrl;

    localparam int NB = 4;
    localparam int HT = 4;
    localparam logic [1:0] OP_HALT = 2'd0, OP_RESUME = 2'd1, OP_STEP = 2'd2, OP_CLEAR = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i;
    logic [NB-1:0] cmd_mask_i, group_mask_i, bp_i, halted_i;
    logic [NB-1:0] cpu_stall_o, status_halted_o, status_bp_o, status_timeout_o;

    always #5 clk = ~clk;

    adbg_core_run_ctrl #(.NB_CORES(NB), .HALT_TIMEOUT(HT)) dut (
        .cpu_clk_i       (clk),
        .cpu_rstn_i      (rst_n),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_op_i        (cmd_op_i),
        .cmd_mask_i      (cmd_mask_i),
        .group_mask_i    (group_mask_i),
        .bp_i            (bp_i),
        .halted_i        (halted_i),
        .cpu_stall_o     (cpu_stall_o),
        .status_halted_o (status_halted_o),
        .status_bp_o     (status_bp_o),
        .status_timeout_o(status_timeout_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a core is halted, waiting (m_wait = cycles waited, -1 if not),
    // stepping, or otherwise running.
    bit m_halted [NB];
    int m_wait   [NB];
    bit m_step   [NB];
    bit m_bp     [NB];
    bit m_to     [NB];

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_halted[i] = 0; m_wait[i] = -1; m_step[i] = 0; m_bp[i] = 0; m_to[i] = 0;
        end
    endtask

    function automatic logic bp_eff(int i);
        logic grp;
        grp = |(bp_i & group_mask_i);
        return bp_i[i] | (group_mask_i[i] & grp);
    endfunction

    function automatic logic exp_ready();
        logic r;
        r = 1'b1;
        for (int i = 0; i < NB; i++) if (m_wait[i] >= 0 || m_step[i]) r = 1'b0;
        return r;
    endfunction

    function automatic logic [NB-1:0] exp_stall();
        logic [NB-1:0] s;
        for (int i = 0; i < NB; i++) s[i] = bp_eff(i) | m_halted[i] | (m_wait[i] >= 0);
        return s;
    endfunction

    function automatic logic [NB-1:0] exp_halted();
        logic [NB-1:0] v;
        for (int i = 0; i < NB; i++) v[i] = m_halted[i];
        return v;
    endfunction

    function automatic logic [NB-1:0] exp_bp();
        logic [NB-1:0] v;
        for (int i = 0; i < NB; i++) v[i] = m_bp[i];
        return v;
    endfunction

    function automatic logic [NB-1:0] exp_to();
        logic [NB-1:0] v;
        for (int i = 0; i < NB; i++) v[i] = m_to[i];
        return v;
    endfunction

    task automatic model_tick();
        logic acc;
        logic sel;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = cmd_valid_i && exp_ready();
        for (int i = 0; i < NB; i++) begin
            sel = acc && cmd_mask_i[i];
            if (m_step[i]) begin
                m_step[i] = 0; m_wait[i] = 0;
                if (bp_eff(i)) m_bp[i] = 1;
            end else if (m_wait[i] >= 0) begin
                if (halted_i[i]) begin
                    m_wait[i] = -1; m_halted[i] = 1;
                end else if (m_wait[i] == HT) begin
                    m_wait[i] = -1; m_halted[i] = 1; m_to[i] = 1;
                end else begin
                    m_wait[i]++;
                end
            end else if (m_halted[i]) begin
                if (sel && cmd_op_i == OP_RESUME) begin
                    m_halted[i] = 0; m_bp[i] = 0;
                end else if (sel && cmd_op_i == OP_STEP) begin
                    m_halted[i] = 0; m_step[i] = 1;
                end
            end else begin
                if (bp_eff(i)) begin
                    m_wait[i] = 0; m_bp[i] = 1;
                end else if (sel && cmd_op_i == OP_HALT) begin
                    m_wait[i] = 0;
                end
            end
            if (sel && cmd_op_i == OP_CLEAR) m_to[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [NB-1:0] mask);
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_mask_i = mask;
        tick();
        cmd_valid_i = 1'b0; cmd_mask_i = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid_i = 0; cmd_op_i = 0; cmd_mask_i = 0;
        group_mask_i = 0; bp_i = 0; halted_i = 0;
        model_reset();
        #12;
        n_checks++; if (cpu_stall_o !== 4'b0000) begin n_fail++; $display("FAIL reset_stall: got %b expected 0000", cpu_stall_o); end
        n_checks++; if (status_halted_o !== 4'b0000) begin n_fail++; $display("FAIL reset_halted: got %b expected 0000", status_halted_o); end
        n_checks++; if (status_bp_o !== 4'b0000) begin n_fail++; $display("FAIL reset_bp: got %b expected 0000", status_bp_o); end
        n_checks++; if (status_timeout_o !== 4'b0000) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0000", status_timeout_o); end
        n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_group_bp();
        group_mask_i = 4'b0101; bp_i = 4'b0001;
        #1;
        n_checks++; if (cpu_stall_o !== 4'b0101) begin n_fail++; $display("FAIL grp_comb_stall: got %b expected 0101", cpu_stall_o); end
        tick();
        bp_i = 0; halted_i = 4'b0101;
        #1;
        n_checks++; if (cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL grp_wait_ready: got %b expected 0", cmd_ready_o); end
        tick();
        halted_i = 0;
        #1;
        n_checks++; if (status_halted_o !== 4'b0101) begin n_fail++; $display("FAIL grp_halted: got %b expected 0101", status_halted_o); end
        n_checks++; if (status_bp_o !== 4'b0101) begin n_fail++; $display("FAIL grp_bp: got %b expected 0101", status_bp_o); end
        n_checks++; if (cpu_stall_o !== 4'b0101) begin n_fail++; $display("FAIL grp_held_stall: got %b expected 0101", cpu_stall_o); end
        issue(OP_RESUME, 4'b0101);
        n_checks++; if (cpu_stall_o !== 4'b0000) begin n_fail++; $display("FAIL grp_resume_stall: got %b expected 0000", cpu_stall_o); end
        n_checks++; if (status_bp_o !== 4'b0000) begin n_fail++; $display("FAIL grp_resume_bp: got %b expected 0000", status_bp_o); end
        group_mask_i = 0;
    endtask

    task automatic test_timeout();
        int n;
        issue(OP_HALT, 4'b0010);
        n = 0;
        while (!cmd_ready_o && n < 20) begin
            n++;
            tick();
        end
        n_checks++; if (n != HT + 1) begin n_fail++; $display("FAIL to_ready_low: got %0d cycles expected %0d", n, HT + 1); end
        n_checks++; if (status_halted_o !== 4'b0010) begin n_fail++; $display("FAIL to_halted: got %b expected 0010", status_halted_o); end
        n_checks++; if (status_timeout_o !== 4'b0010) begin n_fail++; $display("FAIL to_flag: got %b expected 0010", status_timeout_o); end
        issue(OP_CLEAR, 4'b0010);
        n_checks++; if (status_timeout_o !== 4'b0000) begin n_fail++; $display("FAIL to_clear: got %b expected 0000", status_timeout_o); end
        n_checks++; if (status_halted_o !== 4'b0010) begin n_fail++; $display("FAIL to_clear_halted: got %b expected 0010", status_halted_o); end
        issue(OP_RESUME, 4'b0010);
        n_checks++; if (cpu_stall_o !== 4'b0000) begin n_fail++; $display("FAIL to_resume_stall: got %b expected 0000", cpu_stall_o); end
    endtask

    task automatic test_step();
        halted_i = 4'b0001;
        issue(OP_HALT, 4'b0001);
        tick();
        halted_i = 0;
        n_checks++; if (status_halted_o !== 4'b0001) begin n_fail++; $display("FAIL step_pre_halted: got %b expected 0001", status_halted_o); end
        issue(OP_STEP, 4'b0001);
        n_checks++; if (cpu_stall_o[0] !== 1'b0) begin n_fail++; $display("FAIL step_release: got %b expected 0", cpu_stall_o[0]); end
        n_checks++; if (cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL step_ready: got %b expected 0", cmd_ready_o); end
        tick();
        n_checks++; if (cpu_stall_o[0] !== 1'b1) begin n_fail++; $display("FAIL step_restall: got %b expected 1", cpu_stall_o[0]); end
        n_checks++; if (status_halted_o[0] !== 1'b0) begin n_fail++; $display("FAIL step_wait_halted: got %b expected 0", status_halted_o[0]); end
        halted_i = 4'b0001;
        tick();
        halted_i = 0;
        n_checks++; if (status_halted_o !== 4'b0001) begin n_fail++; $display("FAIL step_rehalted: got %b expected 0001", status_halted_o); end
        n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL step_end_ready: got %b expected 1", cmd_ready_o); end
        issue(OP_RESUME, 4'b0001);
    endtask

    task automatic test_resume();
        bp_i = 4'b0001;
        #1;
        n_checks++; if (cpu_stall_o !== 4'b0001) begin n_fail++; $display("FAIL res_bp_stall: got %b expected 0001", cpu_stall_o); end
        tick();
        bp_i = 0; halted_i = 4'b0001;
        tick();
        halted_i = 0;
        n_checks++; if (status_bp_o !== 4'b0001) begin n_fail++; $display("FAIL res_bp_flag: got %b expected 0001", status_bp_o); end
        issue(OP_RESUME, 4'b0001);
        n_checks++; if (cpu_stall_o[0] !== 1'b0) begin n_fail++; $display("FAIL res_stall: got %b expected 0", cpu_stall_o[0]); end
        n_checks++; if (status_bp_o[0] !== 1'b0) begin n_fail++; $display("FAIL res_bp_clr: got %b expected 0", status_bp_o[0]); end
        issue(OP_RESUME, 4'b0001);
        n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL res_again_ready: got %b expected 1", cmd_ready_o); end
        n_checks++; if (cpu_stall_o !== 4'b0000) begin n_fail++; $display("FAIL res_again_stall: got %b expected 0000", cpu_stall_o); end
    endtask

    task automatic test_halt_bp_same();
        cmd_valid_i = 1'b1; cmd_op_i = OP_HALT; cmd_mask_i = 4'b1000; bp_i = 4'b1000;
        #1;
        n_checks++; if (cpu_stall_o !== 4'b1000) begin n_fail++; $display("FAIL hb_comb_stall: got %b expected 1000", cpu_stall_o); end
        tick();
        cmd_valid_i = 1'b0; cmd_mask_i = 0; bp_i = 0;
        n_checks++; if (status_bp_o !== 4'b1000) begin n_fail++; $display("FAIL hb_bp_flag: got %b expected 1000", status_bp_o); end
        n_checks++; if (cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL hb_wait_ready: got %b expected 0", cmd_ready_o); end
        halted_i = 4'b1000;
        tick();
        halted_i = 0;
        tick();
        n_checks++; if (status_halted_o !== 4'b1000) begin n_fail++; $display("FAIL hb_single_wait: got %b expected 1000", status_halted_o); end
        n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL hb_ready_after: got %b expected 1", cmd_ready_o); end
        issue(OP_RESUME, 4'b1000);
    endtask

    task automatic test_reset_mid();
        issue(OP_HALT, 4'b0100);
        n_checks++; if (cpu_stall_o !== 4'b0100) begin n_fail++; $display("FAIL rm_stall_before: got %b expected 0100", cpu_stall_o); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (cpu_stall_o !== 4'b0000) begin n_fail++; $display("FAIL rm_async_stall: got %b expected 0000", cpu_stall_o); end
        n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL rm_async_ready: got %b expected 1", cmd_ready_o); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        group_mask_i = 4'($urandom_range(0, 15));
        for (int c = 0; c < 600; c++) begin
            cmd_valid_i = ($urandom_range(0, 2) == 0);
            cmd_op_i    = 2'($urandom_range(0, 3));
            cmd_mask_i  = 4'($urandom_range(0, 15));
            bp_i        = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            for (int i = 0; i < NB; i++) halted_i[i] = ($urandom_range(0, 5) == 0);
            #1;
            n_checks++; if (cpu_stall_o !== exp_stall()) begin n_fail++; $display("FAIL rnd_stall c=%0d: got %b expected %b", c, cpu_stall_o, exp_stall()); end
            n_checks++; if (cmd_ready_o !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, cmd_ready_o, exp_ready()); end
            tick();
            n_checks++; if (status_halted_o !== exp_halted()) begin n_fail++; $display("FAIL rnd_halted c=%0d: got %b expected %b", c, status_halted_o, exp_halted()); end
            n_checks++; if (status_bp_o !== exp_bp()) begin n_fail++; $display("FAIL rnd_bp c=%0d: got %b expected %b", c, status_bp_o, exp_bp()); end
            n_checks++; if (status_timeout_o !== exp_to()) begin n_fail++; $display("FAIL rnd_timeout c=%0d: got %b expected %b", c, status_timeout_o, exp_to()); end
        end
        cmd_valid_i = 0; bp_i = 0; halted_i = 0;
    endtask

    initial begin
        test_reset();
        test_group_bp();
        test_timeout();
        test_step();
        test_resume();
        test_halt_bp_same();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
